// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the five-stage pipeline sequencer.
//   state_e      : sequencer FSM state (2-bit)
//   stage_t      : per-stage tracking entry {v, wr_en, wr_sel[2:0], halt}
//   HALT_OPCODE  : opcode value decoded as HALT
//   wrHit()      : does a packed write key {writes, wr_sel} target register sel
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } state_e;

    typedef struct packed {
        logic       v;
        logic       wr_en;
        logic [2:0] wr_sel;
        logic       halt;
    } stage_t;

    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    // Key layout is {stage writes a register, destination select}.
    function automatic logic wrHit(input logic [3:0] key, input logic [2:0] sel);
        return key[3] && (key[2:0] == sel);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
// Combinational RAW detector: compares the decode-stage source selects against
// the destinations held in EXE, MEM and WB. The WB compare is dropped when the
// register file forwards a same-cycle write to its read ports.
// Ports:
//   dec_v_i               decode slot holds a valid instruction
//   rs_sel_i / rs_used_i  first source select and its use flag
//   rt_sel_i / rt_used_i  second source select and its use flag
//   exe_key_i, mem_key_i, wb_key_i  {writes, wr_sel} of each downstream stage
//   raw_o                 decode must wait for an older write
// -----------------------------------------------------------------------------
module hazard_cmp
    import pipe_pkg::*;
#(
    parameter int RF_BYPASS = 0
) (
    input  logic       dec_v_i,
    input  logic [2:0] rs_sel_i,
    input  logic       rs_used_i,
    input  logic [2:0] rt_sel_i,
    input  logic       rt_used_i,
    input  logic [3:0] exe_key_i,
    input  logic [3:0] mem_key_i,
    input  logic [3:0] wb_key_i,
    output logic       raw_o
);

    logic rsHit;
    logic rtHit;

    // R0 is an ordinary register here, so no select is exempt from the compare.
    always_comb begin
        rsHit = wrHit(exe_key_i, rs_sel_i) || wrHit(mem_key_i, rs_sel_i) ||
                ((RF_BYPASS == 0) && wrHit(wb_key_i, rs_sel_i));
        rtHit = wrHit(exe_key_i, rt_sel_i) || wrHit(mem_key_i, rt_sel_i) ||
                ((RF_BYPASS == 0) && wrHit(wb_key_i, rt_sel_i));
        raw_o = dec_v_i && ((rs_used_i && rsHit) || (rt_used_i && rtHit));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central sequencer for the fetch/decode/execute/memory/writeback pipeline.
// Drives the PC and pipeline-register enables, inserts bubbles on RAW hazards,
// flushes wrong-path work on a redirect from execute, freezes while data
// memory is busy, and drains the pipe on HALT.
// Ports:
//   clk, rst (async, active-low)
//   dec_rs_sel/used, dec_rt_sel/used, dec_wr_sel/en, dec_halt : decode fields
//   exe_redirect : taken branch/jump resolved in execute
//   mem_busy     : data memory cannot complete this cycle
//   pc_en, ftch_dec_en, dec_exe_en, exe_mem_en, mem_wb_en : load enables
//   dec_kill, exe_kill : load NOP / bubble on the matching enable
//   wb_commit    : WB holds a valid instruction
//   halt_done, err : sticky status until reset
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int RF_BYPASS = 0,
    parameter int MAX_WAIT  = 64,
    parameter int CNT_W     = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dec_rs_sel,
    input  logic       dec_rs_used,
    input  logic [2:0] dec_rt_sel,
    input  logic       dec_rt_used,
    input  logic [2:0] dec_wr_sel,
    input  logic       dec_wr_en,
    input  logic       dec_halt,
    input  logic       exe_redirect,
    input  logic       mem_busy,
    output logic       pc_en,
    output logic       ftch_dec_en,
    output logic       dec_exe_en,
    output logic       exe_mem_en,
    output logic       mem_wb_en,
    output logic       dec_kill,
    output logic       exe_kill,
    output logic       wb_commit,
    output logic       halt_done,
    output logic       err
);

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e           state_q, state_d;
    logic             ret_q, ret_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0] waitNext;
    logic             err_q, err_d;
    logic             haltDone_q, haltDone_d;

    logic             decValid_q;
    stage_t           exeStage_q, memStage_q, wbStage_q;
    stage_t           exeIn;

    logic [3:0]       exeKey, memKey, wbKey;
    logic             raw;
    logic             drainMode;

    assign exeKey = {exeStage_q.v & exeStage_q.wr_en, exeStage_q.wr_sel};
    assign memKey = {memStage_q.v & memStage_q.wr_en, memStage_q.wr_sel};
    assign wbKey  = {wbStage_q.v  & wbStage_q.wr_en,  wbStage_q.wr_sel};

    hazard_cmp #(
        .RF_BYPASS(RF_BYPASS)
    ) u_hazard (
        .dec_v_i  (decValid_q),
        .rs_sel_i (dec_rs_sel),
        .rs_used_i(dec_rs_used),
        .rt_sel_i (dec_rt_sel),
        .rt_used_i(dec_rt_used),
        .exe_key_i(exeKey),
        .mem_key_i(memKey),
        .wb_key_i (wbKey),
        .raw_o    (raw)
    );

    // MEM_WAIT borrows the rules of the state it interrupted; ret_q remembers it.
    assign drainMode = (state_q == ST_DRAIN) || ((state_q == ST_MEM_WAIT) && ret_q);

    // Counter saturates at the limit so a very long stall cannot wrap it.
    assign waitNext = (waitCnt_q == WAIT_LIMIT) ? waitCnt_q : (waitCnt_q + CNT_ONE);

    // Next-state and enable decode, priority: busy > redirect > raw > halt > normal.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        waitCnt_d   = waitCnt_q;
        err_d       = err_q;
        haltDone_d  = haltDone_q;
        pc_en       = 1'b0;
        ftch_dec_en = 1'b0;
        dec_exe_en  = 1'b0;
        exe_mem_en  = 1'b0;
        mem_wb_en   = 1'b0;
        dec_kill    = 1'b0;
        exe_kill    = 1'b0;

        case (state_q)
            ST_RUN, ST_MEM_WAIT, ST_DRAIN: begin
                if (mem_busy) begin
                    state_d   = ST_MEM_WAIT;
                    ret_d     = drainMode;
                    waitCnt_d = waitNext;
                    if (waitNext == WAIT_LIMIT) begin
                        err_d = 1'b1;
                    end
                end else begin
                    waitCnt_d = '0;
                    state_d   = drainMode ? ST_DRAIN : ST_RUN;
                    if (exe_redirect) begin
                        pc_en       = 1'b1;
                        ftch_dec_en = 1'b1;
                        dec_exe_en  = 1'b1;
                        exe_mem_en  = 1'b1;
                        mem_wb_en   = 1'b1;
                        dec_kill    = 1'b1;
                        exe_kill    = 1'b1;
                    end else if (raw) begin
                        dec_exe_en  = 1'b1;
                        exe_kill    = 1'b1;
                        exe_mem_en  = 1'b1;
                        mem_wb_en   = 1'b1;
                    end else if (drainMode) begin
                        ftch_dec_en = 1'b1;
                        dec_kill    = 1'b1;
                        dec_exe_en  = 1'b1;
                        exe_mem_en  = 1'b1;
                        mem_wb_en   = 1'b1;
                        if (wbStage_q.v && wbStage_q.halt) begin
                            state_d    = ST_HALTED;
                            haltDone_d = 1'b1;
                        end
                    end else if (decValid_q && dec_halt) begin
                        ftch_dec_en = 1'b1;
                        dec_kill    = 1'b1;
                        dec_exe_en  = 1'b1;
                        exe_mem_en  = 1'b1;
                        mem_wb_en   = 1'b1;
                        state_d     = ST_DRAIN;
                    end else begin
                        pc_en       = 1'b1;
                        ftch_dec_en = 1'b1;
                        dec_exe_en  = 1'b1;
                        exe_mem_en  = 1'b1;
                        mem_wb_en   = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
            end
            default: begin
                err_d   = 1'b1;
                state_d = ST_RUN;
            end
        endcase
    end

    // Entry loaded into EXE; a killed slot enters as an all-zero bubble.
    always_comb begin
        exeIn = '0;
        if (!exe_kill) begin
            exeIn.v      = decValid_q;
            exeIn.wr_en  = dec_wr_en;
            exeIn.wr_sel = dec_wr_sel;
            exeIn.halt   = dec_halt;
        end
    end

    // FSM, status and stage tracking; tracking moves only with its enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            ret_q      <= 1'b0;
            waitCnt_q  <= '0;
            err_q      <= 1'b0;
            haltDone_q <= 1'b0;
            decValid_q <= 1'b0;
            exeStage_q <= '0;
            memStage_q <= '0;
            wbStage_q  <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            waitCnt_q  <= waitCnt_d;
            err_q      <= err_d;
            haltDone_q <= haltDone_d;
            if (ftch_dec_en) begin
                decValid_q <= ~dec_kill;
            end
            if (dec_exe_en) begin
                exeStage_q <= exeIn;
            end
            if (exe_mem_en) begin
                memStage_q <= exeStage_q;
            end
            if (mem_wb_en) begin
                wbStage_q <= memStage_q;
            end
        end
    end

    assign wb_commit = wbStage_q.v && (state_q != ST_HALTED);
    assign halt_done = haltDone_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. Two instances share stimulus: one without
// register-file bypass (main) and one with it (bubble-count comparison only).
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dec_rs_sel, dec_rt_sel, dec_wr_sel;
    logic       dec_rs_used, dec_rt_used, dec_wr_en, dec_halt;
    logic       exe_redirect, mem_busy;

    logic pc_en, ftch_dec_en, dec_exe_en, exe_mem_en, mem_wb_en;
    logic dec_kill, exe_kill, wb_commit, halt_done, err;

    logic bPcEn, bFdEn, bDeEn, bEmEn, bMwEn;
    logic bDecKill, bExeKill, bCommit, bHaltDone, bErr;

    logic [6:0] enVec, bEnVec;

    int checks = 0;
    int errors = 0;

    // Enable vector layout: {pc, ftch_dec, dec_exe, exe_mem, mem_wb, dec_kill, exe_kill}
    localparam logic [6:0] EN_NORMAL = 7'b1111100;
    localparam logic [6:0] EN_STALL  = 7'b0000000;
    localparam logic [6:0] EN_REDIR  = 7'b1111111;
    localparam logic [6:0] EN_RAW    = 7'b0011101;
    localparam logic [6:0] EN_HALT   = 7'b0111110;

    always #5 clk = ~clk;

    assign enVec  = {pc_en, ftch_dec_en, dec_exe_en, exe_mem_en, mem_wb_en, dec_kill, exe_kill};
    assign bEnVec = {bPcEn, bFdEn, bDeEn, bEmEn, bMwEn, bDecKill, bExeKill};

    pipe_ctrl #(.RF_BYPASS(0), .MAX_WAIT(64), .CNT_W(7)) dut (
        .clk(clk), .rst(rst),
        .dec_rs_sel(dec_rs_sel), .dec_rs_used(dec_rs_used),
        .dec_rt_sel(dec_rt_sel), .dec_rt_used(dec_rt_used),
        .dec_wr_sel(dec_wr_sel), .dec_wr_en(dec_wr_en), .dec_halt(dec_halt),
        .exe_redirect(exe_redirect), .mem_busy(mem_busy),
        .pc_en(pc_en), .ftch_dec_en(ftch_dec_en), .dec_exe_en(dec_exe_en),
        .exe_mem_en(exe_mem_en), .mem_wb_en(mem_wb_en),
        .dec_kill(dec_kill), .exe_kill(exe_kill), .wb_commit(wb_commit),
        .halt_done(halt_done), .err(err)
    );

    pipe_ctrl #(.RF_BYPASS(1), .MAX_WAIT(64), .CNT_W(7)) dutByp (
        .clk(clk), .rst(rst),
        .dec_rs_sel(dec_rs_sel), .dec_rs_used(dec_rs_used),
        .dec_rt_sel(dec_rt_sel), .dec_rt_used(dec_rt_used),
        .dec_wr_sel(dec_wr_sel), .dec_wr_en(dec_wr_en), .dec_halt(dec_halt),
        .exe_redirect(exe_redirect), .mem_busy(mem_busy),
        .pc_en(bPcEn), .ftch_dec_en(bFdEn), .dec_exe_en(bDeEn),
        .exe_mem_en(bEmEn), .mem_wb_en(bMwEn),
        .dec_kill(bDecKill), .exe_kill(bExeKill), .wb_commit(bCommit),
        .halt_done(bHaltDone), .err(bErr)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [6:0] actual, input logic [6:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    // Drive the decode-slot instruction plus the execute/memory side inputs.
    task automatic applyStimulus(input logic [2:0] rs, input logic rsUsed,
                                 input logic [2:0] rt, input logic rtUsed,
                                 input logic [2:0] wr, input logic wrEn,
                                 input logic hlt, input logic redir, input logic busy);
        dec_rs_sel   = rs;
        dec_rs_used  = rsUsed;
        dec_rt_sel   = rt;
        dec_rt_used  = rtUsed;
        dec_wr_sel   = wr;
        dec_wr_en    = wrEn;
        dec_halt     = hlt;
        exe_redirect = redir;
        mem_busy     = busy;
        #1;
    endtask

    task automatic nopStim(input logic redir, input logic busy);
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, redir, busy);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Reset is applied and released mid-cycle; the cycle after release is C0.
    task automatic doReset();
        rst = 1'b0;
        nopStim(1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rstErr", 7'(err), 7'd0);
        checkOutput("rstHaltDone", 7'(halt_done), 7'd0);
        checkOutput("rstCommit", 7'(wb_commit), 7'd0);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;

        // Reset state: enables assert straight away in RUN.
        doReset();
        checkOutput("rstEnables", enVec, EN_NORMAL);
        checkOutput("rstBypEnables", bEnVec, EN_NORMAL);

        // Back-to-back RAW on R3: 3 bubbles without bypass, 2 with.
        nextCycle();
        applyStimulus(3'd1, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rawProducer", enVec, EN_NORMAL);
        nextCycle();
        applyStimulus(3'd3, 1'b1, 3'd4, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rawEn%0d", i), enVec, (i < 3) ? EN_RAW : EN_NORMAL);
            checkOutput($sformatf("rawBypEn%0d", i), bEnVec, (i < 2) ? EN_RAW : EN_NORMAL);
            if (i == 2) begin
                checkOutput("rawProducerCommit", 7'(wb_commit), 7'd1);
            end
            nextCycle();
        end

        // R0 is compared like any other register.
        doReset();
        nextCycle();
        applyStimulus(3'd1, 1'b1, 3'd2, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'd5, 1'b0, 3'd0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rawR0", enVec, EN_RAW);

        // Taken branch: flush decode and the fetched slot, no stall.
        doReset();
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("brEn", enVec, EN_REDIR);
        nextCycle();
        nopStim(1'b0, 1'b0);
        checkOutput("brNoStall", enVec, EN_NORMAL);
        checkOutput("brCommitOld0", 7'(wb_commit), 7'd1);
        nextCycle();
        checkOutput("brCommitOld1", 7'(wb_commit), 7'd1);
        nextCycle();
        checkOutput("brKilled0", 7'(wb_commit), 7'd0);
        nextCycle();
        checkOutput("brKilled1", 7'(wb_commit), 7'd0);
        nextCycle();
        checkOutput("brTargetCommit", 7'(wb_commit), 7'd1);

        // Memory stall of 5 cycles with a pending RAW in decode.
        doReset();
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'd2, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("stallEn%0d", i), enVec, EN_STALL);
            nextCycle();
        end
        applyStimulus(3'd2, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("stallRelease", enVec, EN_RAW);
        checkOutput("stallErr", 7'(err), 7'd0);
        nextCycle();
        checkOutput("stallCommitLoad", 7'(wb_commit), 7'd1);
        checkOutput("stallRawMem", enVec, EN_RAW);
        nextCycle();
        checkOutput("stallCommitNext", 7'(wb_commit), 7'd1);
        nextCycle();
        checkOutput("stallResume", enVec, EN_NORMAL);

        // HALT with ADD in EXE: drain, ADD commits, then frozen.
        doReset();
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("haltEn", enVec, EN_HALT);
        nextCycle();
        nopStim(1'b0, 1'b0);
        checkOutput("drainEn0", enVec, EN_HALT);
        checkOutput("drainDone0", 7'(halt_done), 7'd0);
        nextCycle();
        checkOutput("drainAddCommit", 7'(wb_commit), 7'd1);
        checkOutput("drainEn1", enVec, EN_HALT);
        nextCycle();
        checkOutput("drainEn2", enVec, EN_HALT);
        checkOutput("drainDone2", 7'(halt_done), 7'd0);
        nextCycle();
        checkOutput("haltDone", 7'(halt_done), 7'd1);
        checkOutput("haltedEn", enVec, EN_STALL);
        checkOutput("haltedCommit", 7'(wb_commit), 7'd0);
        nextCycle();
        nopStim(1'b1, 1'b0);
        checkOutput("haltedRedirEn", enVec, EN_STALL);
        nextCycle();
        nopStim(1'b0, 1'b1);
        checkOutput("haltedBusyEn", enVec, EN_STALL);
        checkOutput("haltedDoneSticky", 7'(halt_done), 7'd1);
        checkOutput("haltedErr", 7'(err), 7'd0);

        // Redirect kills a HALT sitting in decode.
        doReset();
        nextCycle();
        nopStim(1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("rvhEn", enVec, EN_REDIR);
        nextCycle();
        nopStim(1'b0, 1'b0);
        checkOutput("rvhRun", enVec, EN_NORMAL);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput($sformatf("rvhDone%0d", i), 7'(halt_done), 7'd0);
            checkOutput($sformatf("rvhPc%0d", i), 7'(pc_en), 7'd1);
        end

        // Long stall: err at the 64th busy cycle, sticky, cleared by async reset.
        doReset();
        for (int i = 1; i <= 63; i++) begin
            nextCycle();
            nopStim(1'b0, 1'b1);
        end
        checkOutput("wait63Err", 7'(err), 7'd0);
        nextCycle();
        nopStim(1'b0, 1'b1);
        checkOutput("wait64ErrPre", 7'(err), 7'd0);
        nextCycle();
        nopStim(1'b0, 1'b1);
        checkOutput("wait64Err", 7'(err), 7'd1);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            nopStim(1'b0, 1'b0);
            checkOutput($sformatf("errSticky%0d", i), 7'(err), 7'd1);
        end
        nextCycle();
        nopStim(1'b0, 1'b1);
        checkOutput("preRstCommit", 7'(wb_commit), 7'd1);
        nextCycle();
        nopStim(1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("asyncErr", 7'(err), 7'd0);
        checkOutput("asyncHaltDone", 7'(halt_done), 7'd0);
        checkOutput("asyncCommit", 7'(wb_commit), 7'd0);
        mem_busy = 1'b0;
        #1;
        checkOutput("asyncRunEn", enVec, EN_NORMAL);
        rst = 1'b1;
        nextCycle();
        checkOutput("postRstErr", 7'(err), 7'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
